// File: rtl/i2c_slave_write_bit.sv
// Drives one I2C data/ACK bit onto SDA aligned to SCL: SDA valid 1 clk after acceptance in SCL low, finish 1 clk after SCL falls.
// Requester holds bit_write_en until bit_write_finish; dropping it early aborts and releases SDA.
module i2c_slave_write_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_write_en,
    input  logic bit_write_i,
    output logic bit_write_finish,
    input  logic scl_i,
    output logic sda_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2,
        WAIT_FALL = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   scl_last;
    logic   bit_q;
    logic   bit_nxt;
    logic   sda_nxt;
    logic   finish_nxt;
    logic   scl_rise;
    logic   scl_fall;

    assign scl_rise = ~scl_last & scl_i;
    assign scl_fall = scl_last & ~scl_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            scl_last         <= 1'b1;
            bit_q            <= 1'b1;
            sda_o            <= 1'b1;
            bit_write_finish <= 1'b0;
        end else begin
            state            <= state_nxt;
            scl_last         <= scl_i;
            bit_q            <= bit_nxt;
            sda_o            <= sda_nxt;
            bit_write_finish <= finish_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bit_nxt    = bit_q;
        sda_nxt    = sda_o;
        finish_nxt = 1'b0;
        case (state)
            IDLE: begin
                // SDA may only move while SCL is low; otherwise it would look like START/STOP.
                if (bit_write_en) begin
                    if (!scl_i) begin
                        bit_nxt   = bit_write_i;
                        sda_nxt   = bit_write_i;
                        state_nxt = WAIT_HIGH;
                    end else begin
                        state_nxt = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                if (!bit_write_en) begin
                    sda_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (scl_fall) begin
                    bit_nxt   = bit_write_i;
                    sda_nxt   = bit_write_i;
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                sda_nxt = bit_q;
                if (!bit_write_en) begin
                    sda_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (scl_rise) begin
                    state_nxt = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                // Bit stays on SDA after the fall as hold time until the next request or abort.
                sda_nxt = bit_q;
                if (!bit_write_en) begin
                    sda_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (scl_fall) begin
                    finish_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                sda_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_write_bit.sv
// Directed bench for i2c_slave_write_bit with SCL driven by hand, 2 clk low / 2 clk high.
module tb_i2c_slave_write_bit;

    logic clk = 1'b0;
    logic rst_n;
    logic bit_write_en;
    logic bit_write_i;
    logic bit_write_finish;
    logic scl;
    logic sda;

    int n_assert = 0;
    int n_fail   = 0;
    int fin_cnt  = 0;

    always #5 clk = ~clk;

    i2c_slave_write_bit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bit_write_en     (bit_write_en),
        .bit_write_i      (bit_write_i),
        .bit_write_finish (bit_write_finish),
        .scl_i            (scl),
        .sda_o            (sda)
    );

    always @(negedge clk) begin
        if (bit_write_finish === 1'b1) fin_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts with SCL high and paused; accepts on the SCL fall, ends with SCL paused high again.
    task automatic do_bit(input logic b, input string tag);
        scl          = 1'b0;
        bit_write_en = 1'b1;
        bit_write_i  = b;
        tick(); check_bit({tag, ".drive"}, sda, b);
        bit_write_i = ~b;
        tick(); check_bit({tag, ".low2"}, sda, b);
        scl = 1'b1;
        tick(); check_bit({tag, ".rise"}, sda, b);
        check_bit({tag, ".nofin"}, bit_write_finish, 1'b0);
        tick(); check_bit({tag, ".high"}, sda, b);
        scl = 1'b0;
        tick(); check_bit({tag, ".fin"}, bit_write_finish, 1'b1);
        bit_write_en = 1'b0;
        tick(); check_bit({tag, ".fin_w"}, bit_write_finish, 1'b0);
        check_bit({tag, ".hold"}, sda, b);
        scl = 1'b1;
        tick();
        tick(); check_bit({tag, ".pause"}, bit_write_finish, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        pat          = 32'h13579BDF;
        rst_n        = 1'b0;
        bit_write_en = 1'b0;
        bit_write_i  = 1'b0;
        scl          = 1'b1;
        tick();
        tick();
        check_bit("rst.sda", sda, 1'b1);
        check_bit("rst.fin", bit_write_finish, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check_bit("idle.sda", sda, 1'b1);
        check_bit("idle.fin", bit_write_finish, 1'b0);

        // Tests 1 and 2: single bits 0 then 1
        do_bit(1'b0, "t1");
        do_bit(1'b1, "t2");

        // Test 3: 32 bits MSB first
        for (int i = 31; i >= 0; i--) begin
            do_bit(pat[i], $sformatf("t3.b%0d", i));
        end

        // Test 4: request while SCL high must wait for the fall
        do_bit(1'b0, "t4pre");
        bit_write_en = 1'b1;
        bit_write_i  = 1'b1;
        tick(); check_bit("t4.wait1", sda, 1'b0);
        tick(); check_bit("t4.wait2", sda, 1'b0);
        check_bit("t4.nofin", bit_write_finish, 1'b0);
        scl = 1'b0;
        tick(); check_bit("t4.drive", sda, 1'b1);
        tick();
        scl = 1'b1;
        tick(); check_bit("t4.rise", sda, 1'b1);
        check_bit("t4.nofin2", bit_write_finish, 1'b0);
        tick(); check_bit("t4.high", sda, 1'b1);
        scl = 1'b0;
        tick(); check_bit("t4.fin", bit_write_finish, 1'b1);
        bit_write_en = 1'b0;
        tick(); check_bit("t4.fin_w", bit_write_finish, 1'b0);
        scl = 1'b1;
        tick();

        // Test 5: abort in WAIT_HIGH
        scl          = 1'b0;
        bit_write_en = 1'b1;
        bit_write_i  = 1'b0;
        tick(); check_bit("t5.drive", sda, 1'b0);
        bit_write_en = 1'b0;
        tick(); check_bit("t5.release", sda, 1'b1);
        check_bit("t5.nofin", bit_write_finish, 1'b0);
        scl = 1'b1;
        tick();
        tick(); check_bit("t5.nofin_h", bit_write_finish, 1'b0);
        scl = 1'b0;
        tick(); check_bit("t5.nofin_f", bit_write_finish, 1'b0);
        tick();
        scl = 1'b1;
        tick(); check_bit("t5.idle_sda", sda, 1'b1);
        check_bit("t5.idle_fin", bit_write_finish, 1'b0);
        do_bit(1'b0, "t5new");

        // Test 6: asynchronous reset while driving 0
        scl          = 1'b0;
        bit_write_en = 1'b1;
        bit_write_i  = 1'b0;
        tick(); check_bit("t6.drive", sda, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t6.async_sda", sda, 1'b1);
        check_bit("t6.async_fin", bit_write_finish, 1'b0);
        bit_write_en = 1'b0;
        tick(); check_bit("t6.inrst_sda", sda, 1'b1);
        rst_n = 1'b1;
        scl   = 1'b1;
        tick();
        tick();
        do_bit(1'b1, "t6a");
        do_bit(1'b0, "t6b");

        // 2 + 32 + 2 (t4pre, t4) + 1 (t5new) + 2 (t6) completed bits
        check_int("fin_count", fin_cnt, 39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_write_bit.md
Name: i2c_slave_write_bit

Overview:
- Bit-level transmitter for the I2C slave datapath.
- On request, it drives one data bit onto SDA (the slave-to-master direction), aligned to the master's SCL.
- It changes SDA only while SCL is low and holds it through the whole SCL high phase.
- It reports completion on the following SCL falling edge.
- It sits below the slave byte-transmit logic, which issues one request per bit (data bits and ACK/NACK).

Parameters:
- None.

Ports:
- clk  input  1  system clock; the only clock; SCL is sampled on it.
- rst_n  input  1  asynchronous active-low reset.
- bit_write_en  input  1  request/enable; held high by the requester until it sees bit_write_finish.
- bit_write_i  input  1  bit to transmit; sampled when the request is accepted.
- bit_write_finish  output  1  one-clk pulse: bit transmitted, SCL has fallen after its high phase.
- scl_i  input  1  SCL line level, treated as synchronous to clk. Any external synchroniser is outside this block.
- sda_o  output  1  SDA drive value (1 = release/high, 0 = pull low).

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - sda_o = 1
  - bit_write_finish = 0
  - state = IDLE
  - bit latch = 1
  - scl_last = 1
- Edge detect: scl_last is registered from scl_i every clk.
  - rise = ~scl_last & scl_i
  - fall = scl_last & ~scl_i
- States: IDLE, WAIT_LOW, WAIT_HIGH, WAIT_FALL. All outputs are registered.
- IDLE:
  - If bit_write_en=1 and scl_i=0: latch bit_write_i, set sda_o <= bit_write_i, go to WAIT_HIGH.
  - If bit_write_en=1 and scl_i=1: go to WAIT_LOW. SDA must not change while SCL is high, because that would create a false START/STOP.
  - sda_o holds its last value while idle.
- WAIT_LOW:
  - On fall: latch bit_write_i, drive sda_o, go to WAIT_HIGH.
- WAIT_HIGH:
  - sda_o held stable.
  - On rise: go to WAIT_FALL.
- WAIT_FALL:
  - sda_o held stable for the entire SCL high phase.
  - On fall: bit_write_finish <= 1 for exactly one clk, return to IDLE.
  - sda_o keeps the bit after finish (hold time) until the next accepted request or an abort.
- Latency:
  - SDA is valid 1 clk after acceptance in SCL low.
  - finish is asserted on the clk after the clk that samples SCL low following the high phase.
- Abort: bit_write_en=0 in any non-IDLE state returns to IDLE with sda_o <= 1 (release) and no finish pulse.
- Re-request: the request may still be high for one clk after finish, because the requester clears it on seeing finish. The block may accept that cycle; the subsequent drop of bit_write_en aborts it cleanly per the abort rule. Holding bit_write_en high continuously yields back-to-back bits, one per SCL cycle.
- bit_write_i changes after acceptance are ignored until the next request.
- SCL glitches are not filtered. Every registered rise/fall counts.
- Reset mid-operation: immediate return to the reset values, SDA released.

Test Plan:
1. SCL period 4 clk (2 high/2 low); assert en on an SCL fall with bit_write_i=0 -> sda_o=0 before the next SCL rise and stable while SCL high; one-clk finish after the next SCL fall.
2. Same with bit_write_i=1 -> sda_o=1 sampled at the SCL rise; finish pulse exactly 1 clk wide.
3. 32 sequential bits of 0x13579BDF, MSB first, en dropped after each finish, SCL paused between bits -> every bit sampled at SCL rise matches, 0 errors; no spurious finish while SCL is paused.
4. Assert en while SCL is high -> sda_o unchanged until the SCL fall, then the bit is driven; finish occurs after one full SCL high phase.
5. Drop en during WAIT_HIGH -> sda_o=1 next clk, no finish, state IDLE; a new request then works normally.
6. Assert rst_n=0 while driving 0 -> sda_o=1 and finish=0 immediately (asynchronous); normal operation after release.
